iq_slot_select: RTL and testbench



---
 rtl/iq_slot_select.sv | 132 +++++++++++++
 tb/tb_iq_slot_select.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iq_slot_select.sv
// Instruction-queue slot tracker: lowest-free allocation, highest-ready issue, monotonic IDs.
// Define IQ_FLUSH_EN to compile in ID-compare squash of younger entries on flush.
module iq_slot_select #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int ID_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req,
  input  logic                   alloc_ready,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ID_W-1:0]        flushed_id,
  input  logic [NUM_ENTRIES-1:0] wake_vec,
  input  logic                   issue_en,
  output logic                   alloc_ack,
  output logic [IDX_W-1:0]       alloc_idx,
  output logic [ID_W-1:0]        alloc_id,
  output logic                   full,
  output logic                   empty,
  output logic                   issue_valid,
  output logic [IDX_W-1:0]       issue_idx,
  output logic [ID_W-1:0]        issue_id
);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] ready_q, ready_d;
  logic [ID_W-1:0]        id_q [NUM_ENTRIES];
  logic [ID_W-1:0]        id_d [NUM_ENTRIES];
  logic [ID_W-1:0]        next_id_q, next_id_d;
  logic                   issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]       issue_idx_q, issue_idx_d;
  logic [ID_W-1:0]        issue_id_q, issue_id_d;

  logic [NUM_ENTRIES-1:0] squash;
  logic [NUM_ENTRIES-1:0] cand;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_hit;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef IQ_FLUSH_EN
  // Unsigned compare on purpose: IDs are assumed not to wrap within a flush window.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      squash[i] = flush & valid_q[i] & (id_q[i] > flushed_id);
    end
  end
`else
  logic unused_flushed_id;
  assign squash            = '0;
  assign unused_flushed_id = ^flushed_id;
`endif

  assign cand = valid_q & ready_q & ~squash;

  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cand[i]) begin
        sel_idx = IDX_W'(i);
        sel_hit = 1'b1;
      end
    end
  end

  assign full      = &valid_q;
  assign empty     = ~|valid_q;
  assign alloc_ack = alloc_req & ~full & ~stall & ~flush;
  assign alloc_idx = free_idx;
  assign alloc_id  = next_id_q;

  // Squash is applied last so it overrides both issue and allocation on a slot.
  always_comb begin
    valid_d       = valid_q;
    ready_d       = (ready_q | wake_vec) & valid_q;
    id_d          = id_q;
    next_id_d     = next_id_q;
    issue_valid_d = 1'b0;
    issue_idx_d   = issue_idx_q;
    issue_id_d    = issue_id_q;
    if (alloc_ack) begin
      valid_d[free_idx] = 1'b1;
      ready_d[free_idx] = alloc_ready | wake_vec[free_idx];
      id_d[free_idx]    = next_id_q;
      next_id_d         = next_id_q + 1'b1;
    end
    if (issue_en && sel_hit) begin
      valid_d[sel_idx] = 1'b0;
      issue_valid_d    = 1'b1;
      issue_idx_d      = sel_idx;
      issue_id_d       = id_q[sel_idx];
    end
    valid_d = valid_d & ~squash;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      ready_q       <= '0;
      next_id_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      issue_id_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      next_id_q     <= next_id_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      issue_id_q    <= issue_id_d;
    end
  end

  // Slot IDs are only meaningful while the slot is valid, so they need no reset.
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;
  assign issue_id    = issue_id_q;

endmodule

// File: tb/tb_iq_slot_select.sv
// Self-checking bench for iq_slot_select: reference model plus issue scoreboard queue.
// Honours IQ_FLUSH_EN the same way the design does.
module tb_iq_slot_select;

   localparam int NumEntries = 32;
   localparam int IdxW       = 5;
   localparam int IdW        = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  allocReq;
   logic                  allocReady;
   logic                  stall;
   logic                  flush;
   logic [IdW-1:0]        flushedId;
   logic [NumEntries-1:0] wakeVec;
   logic                  issueEn;
   logic                  allocAck;
   logic [IdxW-1:0]       allocIdx;
   logic [IdW-1:0]        allocId;
   logic                  full;
   logic                  empty;
   logic                  issueValid;
   logic [IdxW-1:0]       issueIdx;
   logic [IdW-1:0]        issueId;

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   iq_slot_select #(.NUM_ENTRIES(NumEntries), .IDX_W(IdxW), .ID_W(IdW)) dut (
      .clk(clk), .rst(rst), .alloc_req(allocReq), .alloc_ready(allocReady),
      .stall(stall), .flush(flush), .flushed_id(flushedId), .wake_vec(wakeVec),
      .issue_en(issueEn), .alloc_ack(allocAck), .alloc_idx(allocIdx),
      .alloc_id(allocId), .full(full), .empty(empty), .issue_valid(issueValid),
      .issue_idx(issueIdx), .issue_id(issueId)
   );

   int checks = 0;
   int errors = 0;

   // Reference state of the queue as the bench believes it should be
   bit             mValid [NumEntries];
   bit             mReady [NumEntries];
   logic [IdW-1:0] mId    [NumEntries];
   logic [IdW-1:0] mNextId;
   logic [IdxW-1:0] mLastIdx;
   logic [IdW-1:0]  mLastId;

   typedef struct {
      bit              valid;
      logic [IdxW-1:0] idx;
      logic [IdW-1:0]  id;
   } issueExp_t;

   issueExp_t sbQueue[$];

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < NumEntries; i++) begin
         mValid[i] = 1'b0;
         mReady[i] = 1'b0;
         mId[i]    = '0;
      end
      mNextId  = '0;
      mLastIdx = '0;
      mLastId  = '0;
   endtask

   // Drives one cycle of inputs, checks the combinational outputs against the model's
   // pre-edge view, advances the model, then checks the registered issue outputs.
   task automatic applyStimulus(input bit iRst, input bit iReq, input bit iReady,
                                input bit iStall, input bit iFlush, input logic [IdW-1:0] iFlushedId,
                                input logic [NumEntries-1:0] iWake, input bit iIssueEn);
      bit        mFull, mEmpty, hit, ack, foundFree;
      bit        squash [NumEntries];
      int        freeIdx, selIdx;
      issueExp_t exp;
      rst = iRst; allocReq = iReq; allocReady = iReady; stall = iStall;
      flush = iFlush; flushedId = iFlushedId; wakeVec = iWake; issueEn = iIssueEn;
      #3;
      mFull = 1'b1; mEmpty = 1'b1; foundFree = 1'b0; freeIdx = 0; hit = 1'b0; selIdx = 0;
      for (int i = 0; i < NumEntries; i++) begin
         if (mValid[i]) mEmpty = 1'b0;
         else mFull = 1'b0;
         if (!mValid[i] && !foundFree) begin
            freeIdx = i;
            foundFree = 1'b1;
         end
`ifdef IQ_FLUSH_EN
         squash[i] = iFlush && mValid[i] && (mId[i] > iFlushedId);
`else
         squash[i] = 1'b0;
`endif
         if (mValid[i] && mReady[i] && !squash[i]) begin
            hit = 1'b1;
            selIdx = i;
         end
      end
      ack = iReq && !mFull && !iStall && !iFlush;
      checkOutput("alloc_ack", 64'(allocAck), 64'(ack));
      checkOutput("alloc_idx", 64'(allocIdx), 64'(freeIdx));
      checkOutput("alloc_id", 64'(allocId), 64'(mNextId));
      checkOutput("full", 64'(full), 64'(mFull));
      checkOutput("empty", 64'(empty), 64'(mEmpty));
      if (iRst) begin
         modelReset();
         exp = '{valid: 1'b0, idx: '0, id: '0};
      end else begin
         for (int i = 0; i < NumEntries; i++) begin
            if (iWake[i] && mValid[i]) mReady[i] = 1'b1;
         end
         if (ack) begin
            mValid[freeIdx] = 1'b1;
            mReady[freeIdx] = iReady || iWake[freeIdx];
            mId[freeIdx]    = mNextId;
            mNextId         = mNextId + 1;
         end
         if (iIssueEn && hit) begin
            mValid[selIdx] = 1'b0;
            mLastIdx = IdxW'(selIdx);
            mLastId  = mId[selIdx];
            exp = '{valid: 1'b1, idx: mLastIdx, id: mLastId};
         end else begin
            exp = '{valid: 1'b0, idx: mLastIdx, id: mLastId};
         end
         for (int i = 0; i < NumEntries; i++) begin
            if (squash[i]) mValid[i] = 1'b0;
         end
      end
      sbQueue.push_back(exp);
      @(posedge clk);
      #1;
      exp = sbQueue.pop_front();
      checkOutput("issue_valid", 64'(issueValid), 64'(exp.valid));
      checkOutput("issue_idx", 64'(issueIdx), 64'(exp.idx));
      checkOutput("issue_id", 64'(issueId), 64'(exp.id));
   endtask

   // Shorthand for ordinary cycles with no reset, stall or flush
   task automatic cycle(input bit iReq, input bit iReady, input logic [NumEntries-1:0] iWake, input bit iIssueEn);
      applyStimulus(1'b0, iReq, iReady, 1'b0, 1'b0, '0, iWake, iIssueEn);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   // Directed scenarios first, then a randomised soak against the model
   initial begin
      rst = 1'b1; allocReq = 1'b0; allocReady = 1'b0; stall = 1'b0; flush = 1'b0;
      flushedId = '0; wakeVec = '0; issueEn = 1'b0;
      @(posedge clk);
      #1;
      modelReset();
      doReset();
      checkOutput("reset_empty", 64'(empty), 64'd1);
      checkOutput("reset_alloc_idx", 64'(allocIdx), 64'd0);

      // Three not-ready allocations: nothing may issue yet
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      checkOutput("not_ready_no_issue", 64'(issueValid), 64'd0);

      // Wake slots 1 and 2: slot 2 then slot 1 issue, slot 0 stays
      cycle(1'b0, 1'b0, 32'b0110, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wake_first_idx", 64'(issueIdx), 64'd2);
      checkOutput("wake_first_id", 64'(issueId), 64'd2);
      cycle(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wake_second_idx", 64'(issueIdx), 64'd1);
      checkOutput("slot0_still_valid", 64'(empty), 64'd0);

      // Fill all entries, overflow request, then free slot 5 and refill it
      doReset();
      for (int i = 0; i < NumEntries; i++) cycle(1'b1, 1'b0, '0, 1'b0);
      checkOutput("full_after_fill", 64'(full), 64'd1);
      cycle(1'b1, 1'b0, '0, 1'b0);
      checkOutput("overflow_next_id", 64'(allocId), 64'd32);
      cycle(1'b1, 1'b0, 32'h20, 1'b0);
      cycle(1'b1, 1'b0, '0, 1'b1);
      checkOutput("freed_alloc_idx", 64'(allocIdx), 64'd5);
      cycle(1'b1, 1'b0, '0, 1'b0);
      checkOutput("refill_full", 64'(full), 64'd1);

      // Flush with IDs 0..7 all ready, survivors are IDs <= 3
      doReset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3, '0, 1'b1);
`ifdef IQ_FLUSH_EN
      checkOutput("flush_issue_idx", 64'(issueIdx), 64'd3);
      checkOutput("flush_alloc_idx", 64'(allocIdx), 64'd3);
`else
      checkOutput("flush_issue_idx", 64'(issueIdx), 64'd7);
      checkOutput("flush_alloc_idx", 64'(allocIdx), 64'd7);
`endif
      checkOutput("flush_blocks_alloc", 64'(allocId), 64'd8);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);

      // Reset while full and issuing: everything clears, IDs restart
      doReset();
      for (int i = 0; i < NumEntries; i++) cycle(1'b1, 1'b1, '0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("midrst_empty", 64'(empty), 64'd1);
      checkOutput("midrst_issue_valid", 64'(issueValid), 64'd0);
      cycle(1'b1, 1'b0, '0, 1'b0);
      checkOutput("midrst_realloc_empty", 64'(empty), 64'd0);

      // Randomised soak: model tracks every output each cycle
      for (int n = 0; n < 300; n++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                       1'(($urandom_range(0, 1))), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 40)),
                       32'($urandom) & 32'($urandom), 1'(($urandom_range(0, 2) == 0)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
